// File: rtl/prop_clkrst_pkg.sv
// prop_clkrst_pkg: state encodings, clock-select codes and PLL/oscillator mask for prop_clkrst
package prop_clkrst_pkg;
  typedef enum logic [1:0] {
    RST   = 2'd0,
    RUN   = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;
  localparam logic [2:0] CS_RCFAST = 3'b000;
  localparam logic [2:0] CS_RCSLOW = 3'b001;
  localparam logic [2:0] CS_XINPUT = 3'b010;
  localparam logic [2:0] CS_X1     = 3'b011;
  localparam logic [2:0] CS_X2     = 3'b100;
  localparam logic [2:0] CS_X4     = 3'b101;
  localparam logic [2:0] CS_X8     = 3'b110;
  localparam logic [2:0] CS_X16    = 3'b111;
  localparam logic [1:0] PLL_OSC   = 2'b11;
endpackage

// File: rtl/prop_clkrst_sync.sv
// sync_ff: multi-stage synchronizer for an asynchronous input, reset to its inactive level
module sync_ff #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] r;
  // shift the input through STAGES flops; the last stage is the clean copy
  always_ff @(posedge clk or posedge res)
    if (res) r <= {STAGES{RESET_VAL}};
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/prop_clkrst.sv
// prop_clkrst: DTR reset pulse, external/reboot reset merge and clk_en divider (optional DTR via CLKRST_DTR_EN)
module prop_clkrst
  import prop_clkrst_pkg::*;
#(
  parameter int PULSE_CYCLES = 2400,
  parameter int CNT_W = 24,
  parameter int DIV_W = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       res,
`ifdef CLKRST_DTR_EN
  input  logic       dtr,
`endif
  input  logic       ext_resn,
  input  logic [7:0] cfg,
  output logic       nres,
  output logic       clk_en,
  output logic [1:0] state
);
  localparam logic [DIV_W-1:0] ONE = 1;
  state_t st, nxt;
  logic ext_s, rise, pe;
  logic [7:0] cfgx;
  logic [2:0] cs;
  logic [DIV_W-1:0] acc, inc;
  logic unused_cfg;
  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ext (
    .clk(clk), .res(res), .d(ext_resn), .q(ext_s)
  );
`ifdef CLKRST_DTR_EN
  logic dtr_s, dtr_q;
  logic [CNT_W-1:0] cnt;
  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_dtr (
    .clk(clk), .res(res), .d(dtr), .q(dtr_s)
  );
  assign rise = dtr_s & ~dtr_q;
  // DTR edge history and pulse counter, which runs only while pulsing
  always_ff @(posedge clk or posedge res)
    if (res) begin
      dtr_q <= 1'b0;
      cnt <= '0;
    end else begin
      dtr_q <= dtr_s;
      cnt <= (st == PULSE) ? cnt + 1'b1 : '0;
    end
`else
  logic [CNT_W-1:0] unused_par;
  assign unused_par = CNT_W'(PULSE_CYCLES);
  assign rise = 1'b0;
`endif
  // next state: hold has priority over a DTR rise; ext_s only matters at pulse expiry
  always_comb begin
    nxt = HOLD;
    case (st)
      RST: nxt = HOLD;
      RUN: nxt = (!ext_s || cfgx[7]) ? HOLD : rise ? PULSE : RUN;
`ifdef CLKRST_DTR_EN
      PULSE: nxt = !dtr_s ? RUN : (cnt == CNT_W'(PULSE_CYCLES - 1)) ? (ext_s ? RUN : HOLD) : PULSE;
`endif
      HOLD: nxt = (ext_s && !cfgx[7]) ? RUN : HOLD;
      default: nxt = HOLD;
    endcase
  end
  // state register with nres registered alongside so it is glitch-free
  always_ff @(posedge clk or posedge res)
    if (res) begin
      st <= RST;
      nres <= 1'b0;
    end else begin
      st <= nxt;
      nres <= (nxt == RUN);
    end
  assign state = st;
  assign pe = cfgx[6:5] == PLL_OSC;
  assign cs = cfgx[2:0];
  assign unused_cfg = ^cfgx[4:3];
  // accumulator step; outside RUN the fastest rate keeps the core clocking through reset
  always_comb
    inc = (st != RUN || (pe && cs == CS_X16)) ? ONE << (DIV_W - 1)
        : (pe && cs == CS_X8) ? ONE << (DIV_W - 2)
        : (pe && cs == CS_X4) ? ONE << (DIV_W - 3)
        : ((pe && cs == CS_X2) || cs == CS_RCFAST) ? ONE << (DIV_W - 4)
        : ((pe && cs == CS_X1) || (cfgx[5] && cs == CS_XINPUT)) ? ONE << (DIV_W - 5)
        : (cs == CS_RCSLOW) ? ONE : '0;
  // cfg capture and phase accumulator; the carry out becomes the registered clk_en
  always_ff @(posedge clk or posedge res)
    if (res) begin
      cfgx <= '0;
      acc <= '0;
      clk_en <= 1'b0;
    end else begin
      cfgx <= cfg;
      {clk_en, acc} <= {1'b0, acc} + {1'b0, inc};
    end
endmodule
